// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: RegDst selector codes, the EX control
// vector layout, the bubble control value and the link register index.
package id_ex_stage_pkg;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam int RA_IDX = 31;

  typedef struct packed {
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
    logic mem_to_reg;
    logic alu_src;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: a load sitting in EX whose destination
// is read by the real instruction in ID. Writes to $0 never create a hazard.
module load_use_detect #(
  parameter int AW = 5
) (
  input  logic          valid_ex,
  input  logic          ex_mem_rd,
  input  logic [AW-1:0] ex_write_dst,
  input  logic          valid_id,
  input  logic [AW-1:0] rs_id,
  input  logic [AW-1:0] rt_id,
  input  logic          rs_used_id,
  input  logic          rt_used_id,
  output logic          lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = rs_used_id && (rs_id == ex_write_dst);
  assign rt_hit = rt_used_id && (rt_id == ex_write_dst);
  assign lu     = valid_ex && ex_mem_rd && (ex_write_dst != '0) && valid_id &&
                  (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// memory-stall freeze. Optional WB->ID operand bypass under IDEX_WB_BYPASS_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int ALUOPW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_ID,
  input  logic [AW-1:0]     rs_ID,
  input  logic [AW-1:0]     rt_ID,
  input  logic [AW-1:0]     rd_ID,
  input  logic              rs_used_ID,
  input  logic              rt_used_ID,
  input  logic [1:0]        RegDst_ID,
  input  logic              RegWr_ID,
  input  logic              MemRd_ID,
  input  logic              MemWr_ID,
  input  logic              MemtoReg_ID,
  input  logic              ALUSrc_ID,
  input  logic [ALUOPW-1:0] ALUOp_ID,
  input  logic [DW-1:0]     rd1_ID,
  input  logic [DW-1:0]     rd2_ID,
  input  logic [DW-1:0]     imm32_ID,
  input  logic [DW-1:0]     pc_ID,
`ifdef IDEX_WB_BYPASS_EN
  input  logic              WB_RegWr,
  input  logic [AW-1:0]     WB_WriteDst,
  input  logic [DW-1:0]     WB_data,
`endif
  input  logic              flush_ID_EX,
  input  logic              mem_stall,
  output logic [AW-1:0]     rs_ID_EX_r,
  output logic [AW-1:0]     rt_ID_EX_r,
  output logic [AW-1:0]     WriteDst_ID_EX,
  output logic              EX_RegWr,
  output logic              EX_MemRd,
  output logic              EX_MemWr,
  output logic              EX_MemtoReg,
  output logic              EX_ALUSrc,
  output logic [ALUOPW-1:0] EX_ALUOp,
  output logic [DW-1:0]     rd1_EX,
  output logic [DW-1:0]     rd2_EX,
  output logic [DW-1:0]     imm32_EX,
  output logic [DW-1:0]     pc_EX,
  output logic              valid_EX,
  output logic              PCWr_n,
  output logic              IFIDWr_n,
  output logic [31:0]       bubble_cnt
);

  logic              valid_q, valid_d;
  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [ALUOPW-1:0] aluop_q, aluop_d;
  logic [AW-1:0]     rs_q, rs_d, rt_q, rt_d, wd_q, wd_d;
  logic [DW-1:0]     rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              lu;
  logic              hold;
  logic [AW-1:0]     wd_id;
  logic [DW-1:0]     rd1_cap, rd2_cap;

  load_use_detect #(.AW(AW)) u_lu (
    .valid_ex     (valid_q),
    .ex_mem_rd    (ctrl_q.mem_rd),
    .ex_write_dst (wd_q),
    .valid_id     (valid_ID),
    .rs_id        (rs_ID),
    .rt_id        (rt_ID),
    .rs_used_id   (rs_used_ID),
    .rt_used_id   (rt_used_ID),
    .lu           (lu)
  );

  // A taken branch squashes the dependent instruction, so no hold is needed.
  assign hold = mem_stall || (lu && !flush_ID_EX);

  always_comb begin
    wd_id = '0;
    case (RegDst_ID)
      REGDST_RT: wd_id = rt_ID;
      REGDST_RD: wd_id = rd_ID;
      REGDST_RA: wd_id = AW'(RA_IDX);
      default:   wd_id = '0;
    endcase
  end

`ifdef IDEX_WB_BYPASS_EN
  always_comb begin
    rd1_cap = rd1_ID;
    rd2_cap = rd2_ID;
    if (WB_RegWr && (WB_WriteDst != '0) && (WB_WriteDst == rs_ID)) rd1_cap = WB_data;
    if (WB_RegWr && (WB_WriteDst != '0) && (WB_WriteDst == rt_ID)) rd2_cap = WB_data;
  end
`else
  assign rd1_cap = rd1_ID;
  assign rd2_cap = rd2_ID;
`endif

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wd_d    = wd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (mem_stall) begin
      // freeze: keep every register
    end else if (flush_ID_EX || lu) begin
      // Bubble: control and indices cleared, data registers keep stale values.
      valid_d = 1'b0;
      ctrl_d  = BUBBLE_CTRL;
      aluop_d = '0;
      rs_d    = '0;
      rt_d    = '0;
      wd_d    = '0;
      if (!flush_ID_EX) cnt_d = cnt_q + 32'd1;
    end else begin
      valid_d = valid_ID;
      ctrl_d  = valid_ID ? ex_ctrl_t'{RegWr_ID, MemRd_ID, MemWr_ID, MemtoReg_ID, ALUSrc_ID}
                         : BUBBLE_CTRL;
      aluop_d = valid_ID ? ALUOp_ID : '0;
      rs_d    = rs_ID;
      rt_d    = rt_ID;
      wd_d    = wd_id;
      rd1_d   = rd1_cap;
      rd2_d   = rd2_cap;
      imm_d   = imm32_ID;
      pc_d    = pc_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= BUBBLE_CTRL;
      aluop_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      wd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      aluop_q <= aluop_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wd_q    <= wd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rs_ID_EX_r     = rs_q;
  assign rt_ID_EX_r     = rt_q;
  assign WriteDst_ID_EX = wd_q;
  assign EX_RegWr       = ctrl_q.reg_wr;
  assign EX_MemRd       = ctrl_q.mem_rd;
  assign EX_MemWr       = ctrl_q.mem_wr;
  assign EX_MemtoReg    = ctrl_q.mem_to_reg;
  assign EX_ALUSrc      = ctrl_q.alu_src;
  assign EX_ALUOp       = aluop_q;
  assign rd1_EX         = rd1_q;
  assign rd2_EX         = rd2_q;
  assign imm32_EX       = imm_q;
  assign pc_EX          = pc_q;
  assign valid_EX       = valid_q;
  assign PCWr_n         = hold;
  assign IFIDWr_n       = hold;
  assign bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage against a rule-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_ID;
  logic [4:0]  rs_ID, rt_ID, rd_ID;
  logic        rs_used_ID, rt_used_ID;
  logic [1:0]  RegDst_ID;
  logic        RegWr_ID, MemRd_ID, MemWr_ID, MemtoReg_ID, ALUSrc_ID;
  logic [4:0]  ALUOp_ID;
  logic [31:0] rd1_ID, rd2_ID, imm32_ID, pc_ID;
  logic        flush_ID_EX, mem_stall;
  logic [4:0]  rs_ID_EX_r, rt_ID_EX_r, WriteDst_ID_EX;
  logic        EX_RegWr, EX_MemRd, EX_MemWr, EX_MemtoReg, EX_ALUSrc;
  logic [4:0]  EX_ALUOp;
  logic [31:0] rd1_EX, rd2_EX, imm32_EX, pc_EX;
  logic        valid_EX, PCWr_n, IFIDWr_n;
  logic [31:0] bubble_cnt;
`ifdef IDEX_WB_BYPASS_EN
  logic        WB_RegWr;
  logic [4:0]  WB_WriteDst;
  logic [31:0] WB_data;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .valid_ID(valid_ID),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
    .rs_used_ID(rs_used_ID), .rt_used_ID(rt_used_ID), .RegDst_ID(RegDst_ID),
    .RegWr_ID(RegWr_ID), .MemRd_ID(MemRd_ID), .MemWr_ID(MemWr_ID),
    .MemtoReg_ID(MemtoReg_ID), .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID),
    .rd1_ID(rd1_ID), .rd2_ID(rd2_ID), .imm32_ID(imm32_ID), .pc_ID(pc_ID),
`ifdef IDEX_WB_BYPASS_EN
    .WB_RegWr(WB_RegWr), .WB_WriteDst(WB_WriteDst), .WB_data(WB_data),
`endif
    .flush_ID_EX(flush_ID_EX), .mem_stall(mem_stall),
    .rs_ID_EX_r(rs_ID_EX_r), .rt_ID_EX_r(rt_ID_EX_r), .WriteDst_ID_EX(WriteDst_ID_EX),
    .EX_RegWr(EX_RegWr), .EX_MemRd(EX_MemRd), .EX_MemWr(EX_MemWr),
    .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
    .rd1_EX(rd1_EX), .rd2_EX(rd2_EX), .imm32_EX(imm32_EX), .pc_EX(pc_EX),
    .valid_EX(valid_EX), .PCWr_n(PCWr_n), .IFIDWr_n(IFIDWr_n), .bubble_cnt(bubble_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference view of what EX should hold.
  logic        m_valid, m_regwr, m_memrd, m_memwr, m_memtoreg, m_alusrc;
  logic [4:0]  m_aluop, m_rs, m_rt, m_wd;
  logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] dest_of(input logic [1:0] sel, input logic [4:0] rt,
                                         input logic [4:0] rd);
    if (sel == 2'd0) return rt;
    if (sel == 2'd1) return rd;
    if (sel == 2'd2) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic model_hazard();
    logic reads_dst;
    reads_dst = (rs_used_ID && rs_ID == m_wd) || (rt_used_ID && rt_ID == m_wd);
    return m_valid && m_memrd && (m_wd != 5'd0) && valid_ID && reads_dst;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_regwr = 0; m_memrd = 0; m_memwr = 0; m_memtoreg = 0; m_alusrc = 0;
    m_aluop = 0; m_rs = 0; m_rt = 0; m_wd = 0;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic rsu, input logic rtu,
                           input logic [1:0] rdst, input logic rw, input logic mr,
                           input logic mw, input logic m2r, input logic as,
                           input logic [4:0] op);
    valid_ID = v; rs_ID = rs; rt_ID = rt; rd_ID = rd; rs_used_ID = rsu; rt_used_ID = rtu;
    RegDst_ID = rdst; RegWr_ID = rw; MemRd_ID = mr; MemWr_ID = mw; MemtoReg_ID = m2r;
    ALUSrc_ID = as; ALUOp_ID = op;
    rd1_ID = $urandom; rd2_ID = $urandom; imm32_ID = $urandom; pc_ID = $urandom;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(valid_EX), 32'(m_valid));
    check({tag, ".ctrl"}, 32'({EX_RegWr, EX_MemRd, EX_MemWr, EX_MemtoReg, EX_ALUSrc}),
          32'({m_regwr, m_memrd, m_memwr, m_memtoreg, m_alusrc}));
    check({tag, ".aluop"}, 32'(EX_ALUOp), 32'(m_aluop));
    check({tag, ".idx"}, 32'({rs_ID_EX_r, rt_ID_EX_r, WriteDst_ID_EX}), 32'({m_rs, m_rt, m_wd}));
    check({tag, ".rd1"}, rd1_EX, m_rd1);
    check({tag, ".rd2"}, rd2_EX, m_rd2);
    check({tag, ".imm"}, imm32_EX, m_imm);
    check({tag, ".pc"}, pc_EX, m_pc);
    check({tag, ".cnt"}, bubble_cnt, m_cnt);
  endtask

  // One clock: check holds against current inputs, advance model, check EX.
  task automatic cycle(input string tag);
    logic lu, exp_hold;
    #1;
    lu = model_hazard();
    exp_hold = mem_stall || (lu && !flush_ID_EX);
    check({tag, ".PCWr_n"}, 32'(PCWr_n), 32'(exp_hold));
    check({tag, ".IFIDWr_n"}, 32'(IFIDWr_n), 32'(exp_hold));
    @(posedge clk);
    if (rst) begin
      model_clear(); m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_cnt = 0;
    end else if (mem_stall) begin
      // nothing moves
    end else if (flush_ID_EX || lu) begin
      model_clear();
      if (!flush_ID_EX) m_cnt = m_cnt + 1;
    end else begin
      m_valid = valid_ID;
      m_regwr = valid_ID & RegWr_ID; m_memrd = valid_ID & MemRd_ID;
      m_memwr = valid_ID & MemWr_ID; m_memtoreg = valid_ID & MemtoReg_ID;
      m_alusrc = valid_ID & ALUSrc_ID; m_aluop = valid_ID ? ALUOp_ID : 5'd0;
      m_rs = rs_ID; m_rt = rt_ID; m_wd = dest_of(RegDst_ID, rt_ID, rd_ID);
      m_rd1 = rd1_ID; m_rd2 = rd2_ID; m_imm = imm32_ID; m_pc = pc_ID;
`ifdef IDEX_WB_BYPASS_EN
      if (WB_RegWr && WB_WriteDst != 0 && WB_WriteDst == rs_ID) m_rd1 = WB_data;
      if (WB_RegWr && WB_WriteDst != 0 && WB_WriteDst == rt_ID) m_rd2 = WB_data;
`endif
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic lw(input logic [4:0] base, input logic [4:0] dst);
    set_instr(1, base, dst, 0, 1, 0, 2'd0, 1, 1, 0, 1, 1, 5'd0);
  endtask

  task automatic add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    set_instr(1, rs, rt, rd, 1, 1, 2'd1, 1, 0, 0, 0, 0, 5'd2);
  endtask

  initial begin
    rst = 1; flush_ID_EX = 0; mem_stall = 0;
`ifdef IDEX_WB_BYPASS_EN
    WB_RegWr = 0; WB_WriteDst = 0; WB_data = 0;
`endif
    model_clear(); m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_cnt = 0;
    add(1, 2, 3);
    @(negedge clk);
    cycle("reset0");
    cycle("reset1");
    rst = 0;

    add(1, 2, 3); cycle("add");
    check("add.wd_const", 32'(WriteDst_ID_EX), 32'd3);

    lw(1, 5); cycle("lw5");
    add(5, 7, 6); cycle("lu_bubble");
    check("lu_bubble_cnt_const", bubble_cnt, 32'd1);
    cycle("lu_release");
    check("lu_release_rs_const", 32'(rs_ID_EX_r), 32'd5);

    lw(1, 0); cycle("lw0");
    set_instr(1, 0, 0, 9, 1, 1, 2'd1, 1, 0, 0, 0, 0, 5'd2); cycle("read0");
    lw(1, 5); cycle("lw5b");
    set_instr(1, 4, 5, 0, 1, 0, 2'd0, 1, 0, 0, 0, 1, 5'd2); cycle("addi_rt_dest");

    lw(1, 5); cycle("lw5c");
    add(5, 7, 6); flush_ID_EX = 1; cycle("flush_vs_lu");
    flush_ID_EX = 0;

    lw(2, 9); cycle("lw9");
    add(9, 9, 10); mem_stall = 1;
    for (int i = 0; i < 3; i++) cycle("stall");
    mem_stall = 0; cycle("stall_release_bubble");
    cycle("stall_release_capture");

    lw(2, 9); cycle("lw9b");
    mem_stall = 1; add(9, 1, 2); cycle("stall_pre_rst");
    rst = 1; cycle("rst_mid_stall");
    rst = 0; mem_stall = 0; cycle("after_rst");

`ifdef IDEX_WB_BYPASS_EN
    set_instr(1, 8, 1, 3, 1, 1, 2'd1, 1, 0, 0, 0, 0, 5'd2); rd1_ID = 0;
    WB_RegWr = 1; WB_WriteDst = 8; WB_data = 32'hDEADBEEF;
    cycle("wb_bypass");
    check("wb_bypass_const", rd1_EX, 32'hDEADBEEF);
    WB_RegWr = 0;
`endif

    for (int i = 0; i < 400; i++) begin
      set_instr($urandom_range(0, 5) != 0, 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                5'($urandom_range(0, 6)), 1'($urandom), 1'($urandom),
                2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 1) == 0,
                1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      flush_ID_EX = $urandom_range(0, 7) == 0;
      mem_stall   = $urandom_range(0, 5) == 0;
      rst         = $urandom_range(0, 60) == 0;
`ifdef IDEX_WB_BYPASS_EN
      WB_RegWr = 1'($urandom); WB_WriteDst = 5'($urandom_range(0, 6)); WB_data = $urandom;
`endif
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. Captures decoded operands, register indices and control from ID; drives the registered rs/rt indices and write destination consumed by the EX-stage forwarding unit. Generates PC/IF-ID hold signals and inserts bubbles on load-use hazards; honours branch flush and global memory stall.

Parameters:
DW, 32, datapath width (operands, immediate, PC)
AW, 5, register index width
ALUOPW, 5, ALU opcode width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
valid_ID  in  1  ID holds a real instruction
rs_ID, rt_ID, rd_ID  in  AW  decoded register indices
rs_used_ID, rt_used_ID  in  1  instruction actually reads rs / rt
RegDst_ID  in  2  00=rt, 01=rd, 10=$31
RegWr_ID, MemRd_ID, MemWr_ID, MemtoReg_ID, ALUSrc_ID  in  1  control
ALUOp_ID  in  ALUOPW  ALU opcode
rd1_ID, rd2_ID, imm32_ID, pc_ID  in  DW  operands, sign-extended immediate, PC+4
flush_ID_EX  in  1  branch/jump resolved taken: squash ID
mem_stall  in  1  MEM stage busy: freeze pipeline
rs_ID_EX_r, rt_ID_EX_r, WriteDst_ID_EX  out  AW  registered indices for forwarding
EX_RegWr, EX_MemRd, EX_MemWr, EX_MemtoReg, EX_ALUSrc  out  1  registered control
EX_ALUOp  out  ALUOPW  registered opcode
rd1_EX, rd2_EX, imm32_EX, pc_EX  out  DW  registered data
valid_EX  out  1  EX holds a real instruction
PCWr_n, IFIDWr_n  out  1  hold PC / IF-ID register (active-high hold)
bubble_cnt  out  32  count of inserted load-use bubbles

Behaviour:
- Reset (rst=1 at edge): all registered outputs 0, valid_EX=0, bubble_cnt=0. Bubble = all control 0, valid_EX=0, indices 0; data regs hold value.
- WriteDst at capture: RegDst 00->rt_ID, 01->rd_ID, 10->5'd31, 11->0.
- Load-use hazard (combinational, lu): valid_EX & EX_MemRd & WriteDst_ID_EX!=0 & valid_ID & ((rs_used_ID & rs_ID==WriteDst_ID_EX) | (rt_used_ID & rt_ID==WriteDst_ID_EX)).
- PCWr_n = IFIDWr_n = mem_stall | (lu & ~flush_ID_EX).
- Per-edge priority: rst > mem_stall (hold all, counter unchanged) > flush_ID_EX (load bubble) > lu (load bubble, bubble_cnt+1) > normal capture (valid_EX=valid_ID; control forced 0 when valid_ID=0).
- Latency: one cycle ID->EX. Load-use costs exactly one bubble; next cycle hazard clears because load moved to MEM (forwarding then takes the value).
- $0 destination never triggers lu.
- flush with lu simultaneously: flush wins, no hold, counter unchanged.
- mem_stall with lu: hold, no bubble this cycle; lu re-evaluated after stall releases.
- bubble_cnt wraps at 2^32-1 -> 0.
- Reset mid-stall: clears immediately, outputs deasserted next cycle.

Optional Feature:
IDEX_WB_BYPASS_EN: adds inputs WB_RegWr, WB_WriteDst[AW], WB_data[DW]. When defined, at capture rd1 (rd2) takes WB_data if WB_RegWr & WB_WriteDst!=0 & WB_WriteDst==rs_ID (rt_ID), covering same-cycle regfile write/read. Without it, ports absent, rd1/rd2 captured unmodified (regfile must write-before-read).

Decomposition:
- RegDst encodings, bubble control vector, $31 constant: shared ctrl_encode_def.v.
- Sub-module load_use_detect: pure combinational lu computation; register/counter logic in id_ex_stage.

Test Plan:
- Reset: hold rst 2 cycles with valid inputs -> all outputs 0, valid_EX=0, bubble_cnt=0.
- Normal capture: add $3,$1,$2 (rs=1,rt=2,rd=3,RegDst=01,RegWr=1) -> next cycle rs_ID_EX_r=1, rt_ID_EX_r=2, WriteDst_ID_EX=3, EX_RegWr=1.
- Load-use: lw $5 in EX, add $6,$5,$7 in ID -> PCWr_n=IFIDWr_n=1 one cycle, bubble (EX_RegWr=0, valid_EX=0), bubble_cnt=1; next cycle add captured with rs_ID_EX_r=5.
- No false hazard: lw $0 in EX, ID reads $0 -> no hold; lw $5 in EX, addi $5 uses rt as dest (rt_used=0, rs=4) -> no hold.
- Flush vs lu: lu conditions plus flush_ID_EX=1 -> no hold, bubble loaded, bubble_cnt unchanged; mem_stall=1 for 3 cycles -> all EX outputs frozen, holds asserted.
- With IDEX_WB_BYPASS_EN: WB writes $8=0xDEADBEEF while ID reads rs=8, rd1_ID=0 -> rd1_EX=0xDEADBEEF.
